// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM: round-robin on ties, optional
// port locking with a timeout, and a registered one-cycle read return per port.
module mem_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic        lock0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic        lock1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CW = $clog2(LOCK_MAX) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t          state;
  logic            last_gnt;
  logic [CW-1:0]   cnt;
  logic            timeout;
  logic            rvalid0_q;
  logic            rvalid1_q;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    timeout = (state != IDLE) && (cnt == CNT_LAST);
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        LOCK0:   gnt0 = req0 && !timeout;
        LOCK1:   gnt1 = req1 && !timeout;
        default: ;
      endcase
    end
  end

  // With no grant the port 0 request is presented to the RAM, with writes disabled.
  assign mem_a   = gnt1 ? addr1  : addr0;
  assign mem_wd  = gnt1 ? wdata1 : wdata0;
  assign mem_we  = (gnt0 && we0) || (gnt1 && we1);

  // A read returning while reset is asserted is discarded rather than presented.
  assign rvalid0 = rvalid0_q && !reset;
  assign rvalid1 = rvalid1_q && !reset;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; the later last_gnt assignment on timeout deliberately wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_gnt  <= 1'b0;
      cnt       <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      rvalid0_q <= gnt0 && !we0;
      rvalid1_q <= gnt1 && !we1;
      if (gnt0 && !we0) rdata0 <= mem_rd;
      if (gnt1 && !we1) rdata1 <= mem_rd;

      if (gnt0)      last_gnt <= 1'b0;
      else if (gnt1) last_gnt <= 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (gnt0 && lock0)      state <= LOCK0;
          else if (gnt1 && lock1) state <= LOCK1;
        end
        LOCK0: begin
          if (timeout) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (gnt0 && !lock0) state <= IDLE;
          end
        end
        LOCK1: begin
          if (timeout) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (gnt1 && !lock1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (LOCK_MAX=4) with a behavioural RAM; stimulus
// pushes hand-computed per-cycle expectations that a negedge monitor compares.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        gnt0, rvalid0, gnt1, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

  logic [31:0] ram [256];

  mem_arbiter #(.LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = ram[mem_a[9:2]];
  always @(posedge clk) if (mem_we) ram[mem_a[9:2]] <= mem_wd;

  typedef struct {
    logic        g0, g1, we, rv0, rv1;
    logic [31:0] a, wd;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] rd0_q [$];
  logic [31:0] rd1_q [$];

  int n_vec  = 0;
  int n_miss = 0;

  logic        pend0 = 1'b0, pend1 = 1'b0;
  logic [31:0] pend_d0 = '0, pend_d1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus plus the hand-computed grants (and read data if granted a read).
  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic l0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic eg0, input logic eg1, input logic [31:0] erd);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    e.g0  = eg0;
    e.g1  = eg1;
    e.we  = (eg0 && w0) || (eg1 && w1);
    e.a   = eg1 ? a1 : a0;
    e.wd  = eg1 ? d1 : d0;
    e.rv0 = pend0 && !rst;
    e.rv1 = pend1 && !rst;
    if (e.rv0) rd0_q.push_back(pend_d0);
    if (e.rv1) rd1_q.push_back(pend_d1);
    exp_q.push_back(e);
    pend0   = eg0 && !w0;
    pend1   = eg1 && !w1;
    pend_d0 = erd;
    pend_d1 = erd;
  endtask

  task automatic idle();
    step(1'b0, 0,0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 0,0,32'h0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gnt0",    32'(gnt0),           32'(e.g0));
      check("gnt1",    32'(gnt1),           32'(e.g1));
      check("gnt_both", 32'(gnt0 && gnt1),  32'd0);
      check("mem_we",  32'(mem_we),         32'(e.we));
      check("mem_a",   mem_a,               e.a);
      check("mem_wd",  mem_wd,              e.wd);
      check("rvalid0", 32'(rvalid0),        32'(e.rv0));
      check("rvalid1", 32'(rvalid1),        32'(e.rv1));
    end
    if (rvalid0) begin
      if (rd0_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL rdata0_unexpected at %0t: rvalid0 high with no read outstanding", $time);
      end else check("rdata0", rdata0, rd0_q.pop_front());
    end
    if (rvalid1) begin
      if (rd1_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL rdata1_unexpected at %0t: rvalid1 high with no read outstanding", $time);
      end else check("rdata1", rdata1, rd1_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 | 32'(i);
    ram[5] = 32'hDEADBEEF;

    // Reset with both ports requesting writes: no grant and no RAM write.
    step(1, 1,1,0,32'h40,32'hBAD, 1,1,0,32'h44,32'hBAD, 0,0,32'h0);
    step(1, 1,1,0,32'h40,32'hBAD, 1,1,0,32'h44,32'hBAD, 0,0,32'h0);
    // Single read of RAM[5], granted the same cycle.
    step(0, 1,0,0,32'h14,32'h0, 0,0,0,32'h0,32'h0, 1,0,32'hDEADBEEF);
    idle();
    // Contention round-robin: 1,0,1,0.
    step(0, 1,0,0,32'h14,32'h0, 1,0,0,32'h18,32'h0, 0,1,32'hA000_0006);
    step(0, 1,0,0,32'h14,32'h0, 1,0,0,32'h18,32'h0, 1,0,32'hDEADBEEF);
    step(0, 1,0,0,32'h14,32'h0, 1,0,0,32'h18,32'h0, 0,1,32'hA000_0006);
    step(0, 1,0,0,32'h14,32'h0, 1,0,0,32'h18,32'h0, 1,0,32'hDEADBEEF);
    // Port 1 locks with a write; port 0 held off; unlocking read releases it.
    step(0, 0,0,0,32'h0,32'h0,  1,1,1,32'h20,32'h55AA55AA, 0,1,32'h0);
    step(0, 1,0,0,32'h14,32'h0, 0,0,0,32'h0,32'h0,         0,0,32'h0);
    step(0, 1,0,0,32'h14,32'h0, 1,0,0,32'h20,32'h0,        0,1,32'h55AA55AA);
    step(0, 1,0,0,32'h14,32'h0, 0,0,0,32'h0,32'h0,         1,0,32'hDEADBEEF);
    // Port 1 locks then goes quiet: four locked cycles, then port 0 wins.
    step(0, 1,0,0,32'h14,32'h0, 1,0,1,32'h18,32'h0, 0,1,32'hA000_0006);
    step(0, 1,0,0,32'h14,32'h0, 0,0,0,32'h0,32'h0,  0,0,32'h0);
    step(0, 1,0,0,32'h14,32'h0, 0,0,0,32'h0,32'h0,  0,0,32'h0);
    step(0, 1,0,0,32'h14,32'h0, 0,0,0,32'h0,32'h0,  0,0,32'h0);
    step(0, 1,0,0,32'h14,32'h0, 0,0,0,32'h0,32'h0,  0,0,32'h0);
    step(0, 1,0,0,32'h14,32'h0, 1,0,0,32'h18,32'h0, 1,0,32'hDEADBEEF);
    step(0, 1,0,0,32'h14,32'h0, 1,0,0,32'h18,32'h0, 0,1,32'hA000_0006);
    // Port 0 locks and issues back-to-back until the timeout cuts it off.
    step(0, 1,1,1,32'h30,32'h1, 1,0,0,32'h18,32'h0, 1,0,32'h0);
    step(0, 1,1,1,32'h34,32'h2, 1,0,0,32'h18,32'h0, 1,0,32'h0);
    step(0, 1,1,1,32'h38,32'h3, 1,0,0,32'h18,32'h0, 1,0,32'h0);
    step(0, 1,0,1,32'h30,32'h0, 1,0,0,32'h18,32'h0, 1,0,32'h1);
    step(0, 1,0,1,32'h34,32'h0, 1,0,0,32'h18,32'h0, 0,0,32'h0);
    step(0, 1,0,0,32'h34,32'h0, 1,0,0,32'h18,32'h0, 0,1,32'hA000_0006);
    step(0, 1,0,0,32'h34,32'h0, 0,0,0,32'h0,32'h0,  1,0,32'h2);
    // Write by port 0, read of the same word by port 1 the next cycle.
    step(0, 1,1,0,32'h08,32'h12345678, 0,0,0,32'h0,32'h0, 1,0,32'h0);
    step(0, 0,0,0,32'h0,32'h0,         1,0,0,32'h08,32'h0, 0,1,32'h12345678);
    // Locking read, then reset: lock and pending rvalid are discarded.
    step(0, 1,0,1,32'h14,32'h0, 0,0,0,32'h0,32'h0, 1,0,32'hDEADBEEF);
    step(1, 1,1,0,32'h40,32'hBAD, 1,1,0,32'h44,32'hBAD, 0,0,32'h0);
    step(1, 1,1,0,32'h40,32'hBAD, 1,1,0,32'h44,32'hBAD, 0,0,32'h0);
    step(0, 0,0,0,32'h0,32'h0,  1,0,0,32'h38,32'h0, 0,1,32'h3);
    idle();
    idle();

    @(posedge clk);
    @(negedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("rd0_q_drained", 32'(rd0_q.size()), 32'd0);
    check("rd1_q_drained", 32'(rd1_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 16: maximum consecutive cycles one port may hold a lock.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have, per port n in {0 = CPU, 1 = DMA/debug}: reqn  input  1  access request.
REQ-005 SHALL have weN  input  1: write when high, read when low.
REQ-006 SHALL have lockn  input  1: keep ownership after this access.
REQ-007 SHALL have addrn  input  32: byte address.
REQ-008 SHALL have wdatan  input  32: write data.
REQ-009 SHALL have gntn  output  1: access accepted this cycle.
REQ-010 SHALL have rvalidn  output  1: read data valid.
REQ-011 SHALL have rdatan  output  32: read data.
REQ-012 SHALL have memory side port: mem_we  output  1  write enable to single-port RAM.
REQ-013 SHALL have memory side port: mem_a  output  32  RAM address.
REQ-014 SHALL have memory side port: mem_wd  output  32  RAM write data.
REQ-015 SHALL have memory side port: mem_rd  input  32  RAM read data (combinational from mem_a).

Function
REQ-016 Handshake: a requester SHALL hold req, we, lock, addr and wdata stable until it samples gnt high; a transfer completes in the cycle where req&gnt=1.
REQ-017 At most one gnt SHALL be high per cycle; gntn SHALL never be high while reqn is low.
REQ-018 gnt SHALL be combinational from the current req inputs and the registered state, so an idle arbiter grants in the same cycle.
REQ-019 mem_a and mem_wd SHALL mux the granted port's addr and wdata.
REQ-020 mem_we SHALL equal we & gnt of the granted port; mem_we SHALL be 0 when no grant is given.
REQ-021 With no grant, mem_a and mem_wd SHALL hold port 0 values, with mem_we=0.
REQ-022 Reads: rdatan SHALL register mem_rd in the grant cycle; rvalidn SHALL be high exactly one cycle, the cycle after the grant (latency 1). rdatan SHALL hold its value until the next read by port n.
REQ-023 Writes SHALL produce no rvalid; the write SHALL be committed by RAM on the grant edge.
REQ-024 FSM states SHALL be IDLE, LOCK0 and LOCK1.
REQ-025 In IDLE with only one req high, that port SHALL be granted.
REQ-026 In IDLE with both req high, the port not granted most recently (registered pointer last_gnt, reset 0, so port 1 wins the first tie) SHALL be granted.
REQ-027 last_gnt SHALL update on every grant.
REQ-028 IDLE -> LOCKn SHALL occur on a granted transfer of port n with lockn=1.
REQ-029 In LOCKn, only port n SHALL be grantable; the other port SHALL be held off even if its req is high.
REQ-030 LOCKn -> IDLE SHALL occur on a granted transfer of port n with lockn=0.
REQ-031 LOCKn -> IDLE SHALL also occur on a timeout, with no grant given in the timeout cycle.
REQ-032 Timeout: a counter SHALL reset to 0 on entering LOCKn and increment every cycle in LOCKn. When it reaches LOCK_MAX-1, the next state SHALL be IDLE and last_gnt SHALL be forced to n, so the other port wins the next tie.
REQ-033 Counter width SHALL be clog2(LOCK_MAX)+1; it SHALL not wrap within a lock.
REQ-034 In LOCKn with reqn low, the FSM SHALL remain in LOCKn, hold no grant, and keep counting.
REQ-035 A port granted back-to-back SHALL issue one transfer per cycle with no bubble.
REQ-036 Simultaneous read by one port and release by the other SHALL NOT be possible, because of the single grant.

Reset
REQ-037 While reset is high, at the posedge: state <= IDLE, last_gnt <= 0, lock counter <= 0, rvalid0/1 <= 0, rdata0/1 <= 0.
REQ-038 While reset is high, gnt0, gnt1 and mem_we SHALL be forced 0 combinationally, so no RAM write occurs during reset.
REQ-039 Reset asserted mid-lock or mid-read SHALL discard the lock and any pending rvalid; the first cycle after reset SHALL behave as IDLE.

Verification
REQ-040 Single read: RAM[5]=0xDEADBEEF; req0=1, we0=0, addr0=0x14 -> gnt0=1 the same cycle, mem_a=0x14; next cycle rvalid0=1, rdata0=0xDEADBEEF.
REQ-041 Contention round-robin: req0=req1=1 held for 4 cycles after reset -> grants 1,0,1,0; never both high.
REQ-042 Lock: port1 writes 0x20 with lock1=1, then port0 requests -> port0 blocked. Port1 read 0x20 with lock1=0 -> granted, state IDLE; port0 granted the next cycle.
REQ-043 Timeout: LOCK_MAX=4, port1 locks then drops req1 while req0=1 -> port1 loses the lock after 4 cycles in LOCK1; gnt0=1 on the following cycle.
REQ-044 Reset mid-read: read granted, reset=1 the next cycle -> rvalid0=0, mem_we=0 throughout reset; after release, req1 alone is granted immediately.
REQ-045 Write-then-read same address: port0 writes 0x12345678 to 0x08, port1 reads 0x08 the next cycle -> rdata1=0x12345678.
